// File: rtl/periph_bus_arbiter_if.sv
// Peripheral bus bundle: two requesting masters plus the single decoder port.
// The arbiter connects through the slave modport; masters and decoder use master.
interface periph_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          M0_REQ;
    logic [AW-1:0] M0_ADDR;
    logic [DW-1:0] M0_WD;
    logic          M0_WE;
    logic          M0_ACK;
    logic [DW-1:0] M0_RD;

    logic          M1_REQ;
    logic [AW-1:0] M1_ADDR;
    logic [DW-1:0] M1_WD;
    logic          M1_WE;
    logic          M1_ACK;
    logic [DW-1:0] M1_RD;

    logic [AW-1:0] BUS_ADDR;
    logic [DW-1:0] BUS_WD;
    logic          BUS_WE;
    logic [DW-1:0] BUS_RD;

    modport slave (
        input  M0_REQ, M0_ADDR, M0_WD, M0_WE,
        output M0_ACK, M0_RD,
        input  M1_REQ, M1_ADDR, M1_WD, M1_WE,
        output M1_ACK, M1_RD,
        output BUS_ADDR, BUS_WD, BUS_WE,
        input  BUS_RD
    );

    modport master (
        output M0_REQ, M0_ADDR, M0_WD, M0_WE,
        input  M0_ACK, M0_RD,
        output M1_REQ, M1_ADDR, M1_WD, M1_WE,
        input  M1_ACK, M1_RD,
        input  BUS_ADDR, BUS_WD, BUS_WE,
        output BUS_RD
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and three-phase sequencer (IDLE -> XFER -> RESP)
// sharing one peripheral decoder port between the CPU data port (M0) and a second master (M1).
module periph_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                CLK,
    input  logic                RST_N,
    periph_bus_arbiter_if.slave pb,
    output logic                BUSY,
    output logic [1:0]          DBG_STATE
);
    // Handshake: a master raises REQ with ADDR/WD/WE stable and holds it until it
    // sees its one-cycle ACK; RD is valid with ACK. REQ still high in the ACK cycle
    // is a fresh request at the next IDLE. The decoder answers BUS_RD combinationally.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic          owner_q;      // 0 = M0, 1 = M1
    logic          last_q;       // master that won the previous grant
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;
    logic          bus_we_q;
    logic          m0_ack_q;
    logic          m1_ack_q;
    logic [DW-1:0] m0_rd_q;
    logic [DW-1:0] m1_rd_q;

    logic pick_m1_d;

    // On contention the master that did not win last time goes next.
    assign pick_m1_d = pb.M1_REQ && (!pb.M0_REQ || !last_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wd_q     <= '0;
            bus_we_q <= 1'b0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_rd_q  <= '0;
            m1_rd_q  <= '0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            bus_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pb.M0_REQ || pb.M1_REQ) begin
                        owner_q  <= pick_m1_d;
                        addr_q   <= pick_m1_d ? pb.M1_ADDR : pb.M0_ADDR;
                        wd_q     <= pick_m1_d ? pb.M1_WD   : pb.M0_WD;
                        bus_we_q <= pick_m1_d ? pb.M1_WE   : pb.M0_WE;
                        state_q  <= XFER;
                    end
                end
                XFER: begin
                    // Read data is captured for writes too; the master ignores it.
                    if (owner_q) begin
                        m1_rd_q  <= pb.BUS_RD;
                        m1_ack_q <= 1'b1;
                    end else begin
                        m0_rd_q  <= pb.BUS_RD;
                        m0_ack_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pb.BUS_ADDR = addr_q;
    assign pb.BUS_WD   = wd_q;
    assign pb.BUS_WE   = bus_we_q;
    assign pb.M0_ACK   = m0_ack_q;
    assign pb.M1_ACK   = m1_ack_q;
    assign pb.M0_RD    = m0_rd_q;
    assign pb.M1_RD    = m1_rd_q;
    assign BUSY        = (state_q != IDLE);
    assign DBG_STATE   = state_q;

endmodule
